// File: rtl/dii_arb_mux_rr.sv
// N-input round-robin wormhole arbiter/mux for DII packet streams.
// Optional output skid register enabled by defining DII_ARB_MUX_OUTREG_EN.
module dii_arb_mux_rr #(
  parameter  int N  = 2,
  parameter  int W  = 16,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_first,
  input  logic [N-1:0]   in_last,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_first,
  output logic           out_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy,
  output logic [PW-1:0]  grant_idx
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WORM = 1'b1} state_t;

  state_t        r_state, w_state_next;
  logic [PW-1:0] r_rr_ptr, w_rr_ptr_next;
  logic [PW-1:0] r_grant, w_grant_next;

  logic [W-1:0]  w_ch_data [N];
  logic [N-1:0]  w_cand;
  logic          w_any_cand;
  logic [PW-1:0] w_winner;
  logic [PW-1:0] w_sel;
  logic          w_arb_ready;

  logic          w_a_valid, w_a_first, w_a_last;
  logic [W-1:0]  w_a_data;
  logic [N-1:0]  w_a_ready_vec;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(N - 1)) r = '0;
    else                 r = p + 1'b1;
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      assign w_ch_data[gi] = in_data[gi*W +: W];
      assign w_cand[gi]    = in_valid[gi] & in_first[gi];
    end
  endgenerate

  // Round-robin pick: lowest candidate at or above rr_ptr, else lowest below it.
  always_comb begin
    logic          found_hi, found_lo;
    logic [PW-1:0] win_hi, win_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_cand[j]) begin
        if (PW'(j) >= r_rr_ptr) begin
          found_hi = 1'b1;
          win_hi   = PW'(j);
        end else begin
          found_lo = 1'b1;
          win_lo   = PW'(j);
        end
      end
    end
    w_any_cand = found_hi | found_lo;
    w_winner   = found_hi ? win_hi : win_lo;
  end

  assign w_sel = (r_state == ST_IDLE) ? w_winner : r_grant;

  always_comb begin
    w_a_valid     = 1'b0;
    w_a_first     = 1'b0;
    w_a_last      = 1'b0;
    w_a_data      = '0;
    w_a_ready_vec = '0;
    w_state_next  = r_state;
    w_rr_ptr_next = r_rr_ptr;
    w_grant_next  = r_grant;
    if (!rst) begin
      if (r_state == ST_IDLE) begin
        if (w_any_cand) begin
          w_a_valid               = 1'b1;
          w_a_ready_vec[w_winner] = w_arb_ready;
          // Anything other than an accepted single-flit packet locks the offer.
          if (w_arb_ready && in_last[w_winner]) begin
            w_rr_ptr_next = ptr_inc(w_winner);
          end else begin
            w_grant_next = w_winner;
            w_state_next = ST_WORM;
          end
        end
      end else begin
        w_a_valid              = in_valid[r_grant];
        w_a_ready_vec[r_grant] = w_arb_ready;
        if (in_valid[r_grant] && w_arb_ready && in_last[r_grant]) begin
          w_state_next  = ST_IDLE;
          w_rr_ptr_next = ptr_inc(r_grant);
        end
      end
      if (w_a_valid) begin
        w_a_data  = w_ch_data[w_sel];
        w_a_first = in_first[w_sel];
        w_a_last  = in_last[w_sel];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr_ptr <= w_rr_ptr_next;
      r_grant  <= w_grant_next;
    end
  end

  assign in_ready  = w_a_ready_vec;
  assign busy      = (r_state == ST_WORM);
  assign grant_idx = rst ? '0 : w_sel;

`ifdef DII_ARB_MUX_OUTREG_EN
  logic         r_out_valid, r_out_first, r_out_last;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid, r_skid_first, r_skid_last;
  logic [W-1:0] r_skid_data;

  // Arbiter only pushes while the skid slot is free, breaking out_ready->in_ready.
  assign w_arb_ready = !r_skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_first <= 1'b0;
      r_skid_last  <= 1'b0;
      r_skid_data  <= '0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_first  <= r_skid_first;
        r_out_last   <= r_skid_last;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
        r_skid_first <= 1'b0;
        r_skid_last  <= 1'b0;
        r_skid_data  <= '0;
      end else begin
        r_out_valid <= w_a_valid;
        r_out_first <= w_a_first;
        r_out_last  <= w_a_last;
        r_out_data  <= w_a_data;
      end
    end else if (w_a_valid && !r_skid_valid) begin
      r_skid_valid <= 1'b1;
      r_skid_first <= w_a_first;
      r_skid_last  <= w_a_last;
      r_skid_data  <= w_a_data;
    end
  end

  assign out_valid = r_out_valid;
  assign out_first = r_out_first;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
`else
  assign w_arb_ready = out_ready;
  assign out_valid   = w_a_valid;
  assign out_first   = w_a_first;
  assign out_last    = w_a_last;
  assign out_data    = w_a_data;
`endif

endmodule
